// File: rtl/pwm_decoder.sv
// PWM capture: measures high time (d) and rise-to-rise period (t) in clk cycles,
// with a dead-input timeout. Optional glitch filter enabled by PWM_DEC_FILTER_EN.
module pwm_decoder #(
  parameter logic [31:0] TIMEOUT    = 32'd4_000_000,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic        enable,
  input  logic        pwm_in,
  output logic [31:0] d,
  output logic [31:0] t,
  output logic        valid,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_sync;
  logic        r_prev;
  logic        w_lvl;
  logic        w_rise;
  logic        w_fall;
  logic        w_start;
  logic        w_load;
  logic        w_to;
  logic        w_per_at_max;
  logic [31:0] r_hi_cnt;
  logic [31:0] r_per_cnt;
  logic [31:0] r_d;
  logic [31:0] r_t;
  logic        r_valid;
  logic        r_timeout;

  // Synchronizer and edge-detect history run regardless of enable, so
  // re-enabling never manufactures an edge from stale history.
  always_ff @(posedge clk) begin
    if (res) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking (<=) so every flop samples pre-edge values; blocking
      // here would collapse the two synchronizer stages into one.
      r_sync <= {r_sync[0], pwm_in};
      r_prev <= w_lvl;
    end
  end

`ifdef PWM_DEC_FILTER_EN
  logic       r_filt;
  logic [7:0] r_fcnt;

  // Level follows the synchronized input only after FILTER_LEN agreeing samples.
  always_ff @(posedge clk) begin
    if (res) begin
      r_filt <= 1'b0;
      r_fcnt <= 8'd0;
    end else if (r_sync[1] != r_filt) begin
      if (r_fcnt == 8'(FILTER_LEN - 1)) begin
        r_filt <= r_sync[1];
        r_fcnt <= 8'd0;
      end else begin
        r_fcnt <= r_fcnt + 8'd1;
      end
    end else begin
      r_fcnt <= 8'd0;
    end
  end

  assign w_lvl = r_filt;
`else
  logic w_unused_filter_len;
  assign w_unused_filter_len = ^FILTER_LEN;
  assign w_lvl               = r_sync[1];
`endif

  assign w_rise       = w_lvl & ~r_prev;
  assign w_fall       = ~w_lvl & r_prev;
  assign w_per_at_max = (r_per_cnt == TIMEOUT);

  always_ff @(posedge clk) begin
    if (res) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A rising edge in LOW outranks a simultaneous timeout.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_to        = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_state_nxt = S_HIGH;
            w_start     = 1'b1;
          end
        end
        S_HIGH: begin
          if (w_per_at_max) begin
            w_state_nxt = S_IDLE;
            w_to        = 1'b1;
          end else if (w_fall) begin
            w_state_nxt = S_LOW;
          end
        end
        S_LOW: begin
          if (w_rise) begin
            w_state_nxt = S_HIGH;
            w_start     = 1'b1;
            w_load      = 1'b1;
          end else if (w_per_at_max) begin
            w_state_nxt = S_IDLE;
            w_to        = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Counters saturate at TIMEOUT; results and timeout hold while disabled.
  always_ff @(posedge clk) begin
    if (res) begin
      r_hi_cnt  <= 32'd0;
      r_per_cnt <= 32'd0;
      r_d       <= 32'd0;
      r_t       <= 32'd0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= w_load;
      if (w_load) begin
        r_d       <= r_hi_cnt;
        r_t       <= r_per_cnt;
        r_timeout <= 1'b0;
      end else if (w_to) begin
        r_timeout <= 1'b1;
      end

      if (w_state_nxt == S_IDLE) begin
        r_hi_cnt  <= 32'd0;
        r_per_cnt <= 32'd0;
      end else if (w_start) begin
        r_hi_cnt  <= 32'd1;
        r_per_cnt <= 32'd1;
      end else begin
        if (!w_per_at_max) r_per_cnt <= r_per_cnt + 32'd1;
        if (r_state == S_HIGH && !w_fall && r_hi_cnt != TIMEOUT)
          r_hi_cnt <= r_hi_cnt + 32'd1;
      end
    end
  end

  assign d       = r_d;
  assign t       = r_t;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule
